circ_and_checker: RTL and testbench
===================================

CIRC_AND_CHECKER -- requirements
Module: circ_and_checker

Interface
REQ-001 Parameter NUM_VECTORS, default 16, meaning vectors driven per run (range 1..65535).
REQ-002 Parameter CHK_LAT, default 3, meaning clock edges from the drive edge to the compare edge (range 1..8). 3 matches the two-flop circular AND datapath plus the checker sample.
REQ-003 Parameter ERR_W, default 8, meaning err_count width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request, sampled on posedge clk.
REQ-007 d0  output  1  stimulus bit 0 to the DUT, registered.
REQ-008 d1  output  1  stimulus bit 1 to the DUT, registered.
REQ-009 q0  input  1  DUT result 0.
REQ-010 q1  input  1  DUT result 1.
REQ-011 busy  output  1  high in RUN and DRAIN.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  high in DONE when err_count is 0.
REQ-014 err_count  output  ERR_W  count of mismatching vectors, saturating.
REQ-015 vec_count  output  16  count of vectors driven in the current run.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 Transitions:
- IDLE->RUN on start.
- RUN->DRAIN on the edge after vector NUM_VECTORS-1 is driven.
- DRAIN->DONE on the edge that compares the last vector.
- DONE->RUN on start.
REQ-018 The start edge clears err_count and vec_count, drives vector 0, and enters RUN; start is ignored in RUN and DRAIN.
REQ-019 Vector k drives d0=k[0] and d1=k[1], one vector per cycle; vec_count increments on each drive edge.
REQ-020 d0 and d1 are 0 in IDLE, DRAIN and DONE.
REQ-021 Expected result for vector k is k[0]&k[1]; it is held with a valid flag in a CHK_LAT-deep shift register.
REQ-022 The comparison for vector k occurs at edge (drive edge of k)+CHK_LAT.
REQ-023 A vector mismatches when q0 or q1 differs from the expected value; each mismatching vector adds exactly 1 to err_count.
REQ-024 Treatment of X or Z on q0/q1:
- case-equality compare in simulation;
- X or Z counts as a mismatch.
REQ-025 err_count saturates at 2^ERR_W-1 and never wraps.
REQ-026 No comparison occurs for shift-register slots without a valid flag, i.e. no errors are counted in IDLE or before the first valid slot.
REQ-027 err_count includes the last vector's result on the same edge that done asserts; with start at edge 0, done asserts at edge NUM_VECTORS+CHK_LAT-1.
REQ-028 pass is 0 outside DONE.
REQ-029 err_count and vec_count hold their values in DONE until the next start.

Reset
REQ-030 rst_n low immediately forces:
- state IDLE;
- d0, d1, busy, done, pass = 0;
- err_count, vec_count = 0;
- all valid flags cleared.
REQ-031 Reset mid-RUN or mid-DRAIN abandons the run; no compare is counted for vectors in flight.
REQ-032 After rst_n rises, the block needs a new start before leaving IDLE.

Verification
REQ-033 Ideal DUT model, defaults, start at edge 0 -> d0/d1 walk 0,1,2,3 repeating; done=1 at edge 18; err_count=0, pass=1, vec_count=16.
REQ-034 q0 stuck at 0, q1 correct -> vectors 3,7,11,15 mismatch; err_count=4, pass=0.
REQ-035 q1 stuck at 1, q0 correct -> 12 mismatches; err_count=12, pass=0.
REQ-036 NUM_VECTORS=300, ERR_W=8, both outputs inverted -> err_count saturates at 255, vec_count=300.
REQ-037 rst_n low at edge 7 of a run -> all outputs 0 asynchronously; start after release -> clean run gives err_count=0, pass=1.
REQ-038 start held high through a run and into DONE -> start is ignored while busy; from DONE a restart clears err_count and vec_count, and done falls on the restart edge.

Source files
------------

// File: rtl/circ_and_checker.sv
// Self-checking stimulus generator for a two-flop circular AND datapath.
// Walks vectors 0..NUM_VECTORS-1 on d1/d0 and compares q0/q1 against k[0]&k[1] CHK_LAT edges later.
module circ_and_checker #(
    parameter int NUM_VECTORS = 16,
    parameter int CHK_LAT     = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             d0,
    output logic             d1,
    input  logic             q0,
    input  logic             q1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      vec_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int          TAIL     = CHK_LAT - 1;
    localparam logic [15:0] NUM_VEC  = 16'(NUM_VECTORS);
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    // Saturating increment: the error count sticks at all-ones.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == ERR_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + ERR_W'(1);
        end
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        vec_count_q, vec_count_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               d0_q, d0_d;
    logic               d1_q, d1_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [CHK_LAT-1:0] vld_q, vld_d;
    logic [CHK_LAT-1:0] exp_q, exp_d;
    logic [CHK_LAT-1:0] last_q, last_d;

    logic               drive_s;
    logic [15:0]        drive_idx_s;
    logic               miss_s;

    // Vector index, drive decision and next-state / counter logic.
    always_comb begin
        state_d     = state_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        drive_s     = 1'b0;
        drive_idx_s = 16'd0;
        miss_s      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    err_count_d = '0;
                    vec_count_d = 16'd1;
                    drive_s     = 1'b1;
                    drive_idx_s = 16'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (vec_count_q == NUM_VEC) begin
                    state_d = ST_DRAIN;
                end else begin
                    drive_s     = 1'b1;
                    drive_idx_s = vec_count_q;
                    vec_count_d = vec_count_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DRAIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Tail slot compares this edge; X/Z on q is a mismatch in simulation.
        if (vld_q[TAIL]) begin
            miss_s = (q0 !== exp_q[TAIL]) || (q1 !== exp_q[TAIL]);
            if (miss_s) begin
                err_count_d = sat_inc(err_count_q);
            end else begin
                err_count_d = err_count_q;
            end
            if (last_q[TAIL]) begin
                state_d = ST_DONE;
            end else begin
                state_d = state_d;
            end
        end else begin
            miss_s = 1'b0;
        end
    end

    // Stimulus outputs and the expected-value shift register.
    always_comb begin
        d0_d = 1'b0;
        d1_d = 1'b0;
        vld_d = '0;
        exp_d = '0;
        last_d = '0;
        if (drive_s) begin
            d0_d      = drive_idx_s[0];
            d1_d      = drive_idx_s[1];
            vld_d[0]  = 1'b1;
            exp_d[0]  = drive_idx_s[0] & drive_idx_s[1];
            last_d[0] = (drive_idx_s == LAST_IDX);
        end else begin
            vld_d[0]  = 1'b0;
        end
        for (int i = 1; i < CHK_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            exp_d[i]  = exp_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    // Status flags are decoded from the next state so they are registered.
    always_comb begin
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_count_d == '0);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_count_q <= 16'd0;
            err_count_q <= '0;
            d0_q        <= 1'b0;
            d1_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            vld_q       <= '0;
            exp_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            last_q      <= last_d;
        end
    end

    assign d0        = d0_q;
    assign d1        = d1_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_circ_and_checker.sv
// Directed bench: two checker instances, each closing the loop through a two-flop AND model.
module tb_circ_and_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   mode_a = 0;   // 0 ideal, 1 q0 stuck 0, 2 q1 stuck 1, 3 inverted
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic d0_a, d1_a, q0_a, q1_a, busy_a, done_a, pass_a;
    logic [7:0]  err_a;
    logic [15:0] vec_a;
    logic d0_b, d1_b, q0_b, q1_b, busy_b, done_b, pass_b;
    logic [7:0]  err_b;
    logic [15:0] vec_b;

    logic s1_a = 1'b0, s2_a = 1'b0, s1_b = 1'b0, s2_b = 1'b0;

    // Two-flop AND datapath models feeding each checker.
    always @(posedge clk) begin
        s1_a <= d0_a & d1_a;
        s2_a <= s1_a;
        s1_b <= d0_b & d1_b;
        s2_b <= s1_b;
    end

    assign q0_a = (mode_a == 1) ? 1'b0 : (mode_a == 3) ? ~s2_a : s2_a;
    assign q1_a = (mode_a == 2) ? 1'b1 : (mode_a == 3) ? ~s2_a : s2_a;
    assign q0_b = ~s2_b;
    assign q1_b = ~s2_b;

    circ_and_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .d0(d0_a), .d1(d1_a), .q0(q0_a), .q1(q1_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .vec_count(vec_a)
    );

    circ_and_checker #(.NUM_VECTORS(300), .CHK_LAT(3), .ERR_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .d0(d0_b), .d1(d1_b), .q0(q0_b), .q1(q1_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .vec_count(vec_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected instance reports done; edges counts from the start edge.
    task automatic wait_done(input bit sel_b, input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            step();
            edges++;
            if ((sel_b ? done_b : done_a) === 1'b1) break;
        end
        if (edges >= budget) check("done_timeout", 32'(edges), 32'(budget - 1));
    endtask

    task automatic run_a(input int mode, input string tag, input int exp_err, input int exp_pass);
        int edges;
        mode_a  = mode;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done(1'b0, 40, edges);
        check({tag, "_done_edge"}, 32'(edges), 32'd18);
        check({tag, "_err"}, 32'(err_a), 32'(exp_err));
        check({tag, "_pass"}, 32'(pass_a), 32'(exp_pass));
        check({tag, "_vec"}, 32'(vec_a), 32'd16);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        int edges;
        #2;
        check("rst_outs", {d0_a, d1_a, busy_a, done_a, pass_a}, 32'd0);
        check("rst_cnt", {err_a, vec_a}, 32'd0);
        #20;
        rst_n = 1'b1;
        step();
        step();
        check("idle_after_rst", {busy_a, done_a, d0_a, d1_a}, 32'd0);

        // Ideal run, checking the vector walk edge by edge.
        mode_a  = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("walk_e0", {d1_a, d0_a}, 32'd0);
        check("busy_e0", 32'(busy_a), 32'd1);
        check("vec_e0", 32'(vec_a), 32'd1);
        for (int e = 1; e < 16; e++) begin
            step();
            check($sformatf("walk_e%0d", e), {d1_a, d0_a}, 32'(e % 4));
        end
        step();
        check("drain_d_zero", {d1_a, d0_a}, 32'd0);
        check("drain_busy", 32'(busy_a), 32'd1);
        step();
        check("done_e17", 32'(done_a), 32'd0);
        check("pass_e17", 32'(pass_a), 32'd0);
        step();
        check("done_e18", 32'(done_a), 32'd1);
        check("ideal_err", 32'(err_a), 32'd0);
        check("ideal_pass", 32'(pass_a), 32'd1);
        check("ideal_vec", 32'(vec_a), 32'd16);
        step();
        check("done_hold", {done_a, 8'(err_a), vec_a}, {1'b1, 8'd0, 16'd16});

        run_a(1, "q0_stuck0", 4, 0);
        run_a(2, "q1_stuck1", 12, 0);
        run_a(3, "inverted16", 16, 0);
        run_a(0, "ideal2", 0, 1);

        // Saturation with 300 vectors, all inverted.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        wait_done(1'b1, 400, edges);
        check("sat_done_edge", 32'(edges), 32'd302);
        check("sat_err", 32'(err_b), 32'd255);
        check("sat_vec", 32'(vec_b), 32'd300);
        check("sat_pass", 32'(pass_b), 32'd0);

        // Asynchronous reset mid-run with a faulty DUT, then a clean rerun.
        mode_a  = 3;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int e = 1; e <= 7; e++) step();
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {d0_a, d1_a, busy_a, done_a, pass_a}, 32'd0);
        check("midrst_cnt", {err_a, vec_a}, 32'd0);
        #10;
        rst_n = 1'b1;
        step();
        step();
        step();
        check("midrst_idle", {busy_a, done_a, err_a}, 32'd0);
        run_a(0, "after_rst", 0, 1);

        // Start held high: ignored while busy, restarts from DONE.
        mode_a  = 1;
        start_a = 1'b1;
        step();
        wait_done(1'b0, 40, edges);
        check("held_done_edge", 32'(edges), 32'd18);
        check("held_err", 32'(err_a), 32'd4);
        step();
        check("restart_done", 32'(done_a), 32'd0);
        check("restart_busy", 32'(busy_a), 32'd1);
        check("restart_err", 32'(err_a), 32'd0);
        check("restart_vec", 32'(vec_a), 32'd1);
        start_a = 1'b0;
        mode_a  = 0;
        wait_done(1'b0, 40, edges);
        check("restart_done_edge", 32'(edges), 32'd18);
        check("restart_pass", 32'(pass_a), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
